// File: rtl/rv32i_types.sv
// Shared types for the memory responder: the 32-bit word type and the
// responder FSM state encoding.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } memresp_state_t;

    localparam int unsigned MEMRESP_CNT_W = 4;

    // Word index width for a power-of-two word depth.
    function automatic int unsigned memresp_index_w(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory
// responder (slave). Requests are held by the initiator until mem_resp.
interface mem_responder_if;
    import rv32i_types::*;

    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_byte_enable;
    rv32i_word  mem_address;
    rv32i_word  mem_wdata;
    logic       mem_resp;
    rv32i_word  mem_rdata;
    logic       proto_err;

    modport master (
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_address,
        output mem_wdata,
        input  mem_resp,
        input  mem_rdata,
        input  proto_err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_address,
        input  mem_wdata,
        output mem_resp,
        output mem_rdata,
        output proto_err
    );

endinterface

// File: rtl/mem_responder_ram.sv
// DEPTH_WORDS x 32 storage built as four byte-lane arrays, each with a
// synchronous write and a registered read, so byte enables map cleanly.
module mem_responder_ram
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = memresp_index_w(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [3:0]    i_wbe,
    input  rv32i_word     i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output rv32i_word     o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd_byte;

            always_ff @(posedge clk) begin
                if (i_we && i_wbe[gi]) begin
                    r_mem[i_waddr] <= i_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (i_re) begin
                    r_rd_byte <= r_mem[i_raddr];
                end
            end

            assign o_rdata[8*gi +: 8] = r_rd_byte;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE/BUSY/RESP FSM in front of a
// byte-enabled RAM. Define MEM_RESPONDER_PROTOCOL_CHECK_EN to build the sticky proto_err checker.
module mem_responder
    import rv32i_types::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned AW = memresp_index_w(DEPTH_WORDS);
    localparam logic [MEMRESP_CNT_W-1:0] CNT_LOAD = MEMRESP_CNT_W'(LATENCY - 1);

    memresp_state_t           r_state;
    memresp_state_t           w_state_next;
    logic [MEMRESP_CNT_W-1:0] r_count;
    logic [MEMRESP_CNT_W-1:0] w_count_next;
    logic [AW-1:0]            r_idx;
    rv32i_word                r_wdata;
    logic [3:0]               r_be;
    logic                     r_op_write;
    logic                     r_rdata_valid;

    logic                     w_req;
    logic                     w_capture;
    logic                     w_rd_en;
    logic                     w_wr_en;
    logic [AW-1:0]            w_live_idx;
    logic [AW-1:0]            w_rd_idx;
    rv32i_word                w_ram_rdata;
    logic                     w_unused_addr_bits;

    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_live_idx = bus.mem_address[AW+1:2];
    assign w_unused_addr_bits = ^{bus.mem_address[31:AW+2], bus.mem_address[1:0]};

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_next = RESP;
                        w_count_next = '0;
                    end else begin
                        w_state_next = BUSY;
                        w_count_next = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                // A vanished request aborts silently; otherwise count down to RESP.
                if (!w_req) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count - 1'b1;
                    if (r_count == MEMRESP_CNT_W'(1)) begin
                        w_state_next = RESP;
                    end
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_op_write <= 1'b0;
        end else if (w_capture) begin
            r_idx      <= w_live_idx;
            r_wdata    <= bus.mem_wdata;
            r_be       <= bus.mem_byte_enable;
            r_op_write <= bus.mem_write;
        end
    end

    // The read is launched on the edge entering RESP; with LATENCY=1 that is
    // the capture edge itself, so the live address is used there.
    assign w_rd_idx = w_capture ? w_live_idx : r_idx;
    assign w_rd_en  = (w_state_next == RESP) && (w_capture ? !bus.mem_write : !r_op_write);
    assign w_wr_en  = (r_state == RESP) && r_op_write;

    // RAM output is not reset; this flag forces mem_rdata to zero until the
    // first read after reset reloads the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata_valid <= 1'b0;
        end else if (w_rd_en) begin
            r_rdata_valid <= 1'b1;
        end
    end

    mem_responder_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_idx),
        .i_wbe   (r_be),
        .i_wdata (r_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_rd_idx),
        .o_rdata (w_ram_rdata)
    );

    assign bus.mem_resp  = (r_state == RESP);
    assign bus.mem_rdata = r_rdata_valid ? w_ram_rdata : '0;

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    rv32i_word r_addr_full;
    logic      r_op_read;
    logic      r_proto_err;
    logic      w_violation;

    always_comb begin
        w_violation = 1'b0;
        if (w_capture && bus.mem_read && bus.mem_write) begin
            w_violation = 1'b1;
        end
        if (r_state == BUSY) begin
            if (!w_req) begin
                w_violation = 1'b1;
            end else if ((bus.mem_address != r_addr_full) ||
                         ({bus.mem_read, bus.mem_write} != {r_op_read, r_op_write}) ||
                         (bus.mem_wdata != r_wdata)) begin
                w_violation = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_full <= '0;
            r_op_read   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_capture) begin
                r_addr_full <= bus.mem_address;
                r_op_read   <= bus.mem_read;
            end
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign bus.proto_err = r_proto_err;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: three instances with
// LATENCY 2 (main), 1 (back-to-back) and 4 (abort).
module tb_mem_responder;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus2();
    mem_responder_if bus1();
    mem_responder_if bus4();

    mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mem_responder #(.LATENCY(1), .DEPTH_WORDS(1024)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_responder #(.LATENCY(4), .DEPTH_WORDS(1024)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int checks   = 0;
    int failures = 0;

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
    localparam logic EXP_PERR = 1'b1;
`else
    localparam logic EXP_PERR = 1'b0;
`endif

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        case (sel)
            1: begin
                bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_address = a;
                bus1.mem_wdata = d; bus1.mem_byte_enable = be;
            end
            4: begin
                bus4.mem_read = rd; bus4.mem_write = wr; bus4.mem_address = a;
                bus4.mem_wdata = d; bus4.mem_byte_enable = be;
            end
            default: begin
                bus2.mem_read = rd; bus2.mem_write = wr; bus2.mem_address = a;
                bus2.mem_wdata = d; bus2.mem_byte_enable = be;
            end
        endcase
    endtask

    function automatic logic get_resp(input int sel);
        case (sel)
            1:       return bus1.mem_resp;
            4:       return bus4.mem_resp;
            default: return bus2.mem_resp;
        endcase
    endfunction

    function automatic rv32i_word get_rdata(input int sel);
        case (sel)
            1:       return bus1.mem_rdata;
            4:       return bus4.mem_rdata;
            default: return bus2.mem_rdata;
        endcase
    endfunction

    // Issue one request from an IDLE cycle, wait (bounded) for mem_resp,
    // drop the request and step into the following IDLE cycle.
    task automatic txn(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       output rv32i_word rdata, output int lat);
        lat   = -1;
        rdata = '0;
        drive(sel, rd, wr, a, d, be);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (get_resp(sel)) begin
                lat   = i;
                rdata = get_rdata(sel);
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, a, d, be);
        $display("txn dut=L%0d rd=%0b wr=%0b addr=%h wdata=%h be=%b lat=%0d rdata=%h",
                 sel, rd, wr, a, d, be, lat, rdata);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus2.mem_resp !== 1'b0) begin failures++; $display("FAIL reset_resp: got %b expected 0", bus2.mem_resp); end
        checks++; if (bus2.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 00000000", bus2.mem_rdata); end
        checks++; if (bus2.proto_err !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b expected 0", bus2.proto_err); end
        checks++; if (bus4.mem_resp !== 1'b0) begin failures++; $display("FAIL reset_resp_l4: got %b expected 0", bus4.mem_resp); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_latency;
        rv32i_word rd; int lat;
        txn(2, 1, 0, 32'h0000_0010, 32'h0, 4'h0, rd, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL read_latency: got %0d expected 2", lat); end
        checks++; if (bus2.mem_resp !== 1'b0) begin failures++; $display("FAIL resp_one_cycle: got %b expected 0", bus2.mem_resp); end
    endtask

    task automatic test_byte_enable;
        rv32i_word rd; int lat;
        txn(2, 0, 1, 32'h20, 32'hDEAD_BEEF, 4'hF, rd, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL write_latency: got %0d expected 2", lat); end
        txn(2, 0, 1, 32'h20, 32'h0000_00AA, 4'h1, rd, lat);
        txn(2, 1, 0, 32'h20, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL byte_lane: got %h expected deadbeaa", rd); end
        txn(2, 0, 1, 32'h20, 32'hFFFF_FFFF, 4'h0, rd, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL be0_resp: got %0d expected 2", lat); end
        checks++; if (bus2.mem_rdata !== 32'hDEAD_BEAA) begin failures++; $display("FAIL rdata_hold: got %h expected deadbeaa", bus2.mem_rdata); end
        txn(2, 1, 0, 32'h20, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL be0_unchanged: got %h expected deadbeaa", rd); end
    endtask

    task automatic test_wrap;
        rv32i_word rd; int lat;
        txn(2, 0, 1, 32'h0000_1004, 32'h1234_5678, 4'hF, rd, lat);
        txn(2, 1, 0, 32'h0000_0004, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL addr_wrap: got %h expected 12345678", rd); end
        txn(2, 1, 0, 32'hFFFF_F007, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL addr_high_low_bits: got %h expected 12345678", rd); end
    endtask

    task automatic test_back_to_back;
        rv32i_word rd; int lat;
        txn(2, 0, 1, 32'h24, 32'h0BAD_C0DE, 4'hF, rd, lat);
        txn(2, 1, 0, 32'h24, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0BAD_C0DE) begin failures++; $display("FAIL raw_same_word: got %h expected 0badc0de", rd); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL raw_latency: got %0d expected 2", lat); end
        txn(2, 1, 0, 32'h20, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL neighbour_word: got %h expected deadbeaa", rd); end
        checks++; if (bus2.proto_err !== 1'b0) begin failures++; $display("FAIL perr_clean_traffic: got %b expected 0", bus2.proto_err); end
    endtask

    task automatic test_rw_both;
        rv32i_word rd; int lat;
        txn(2, 1, 1, 32'h30, 32'hCAFE_F00D, 4'hF, rd, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rw_both_latency: got %0d expected 2", lat); end
        checks++; if (bus2.proto_err !== EXP_PERR) begin failures++; $display("FAIL rw_both_perr: got %b expected %b", bus2.proto_err, EXP_PERR); end
        txn(2, 1, 0, 32'h30, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL rw_both_is_write: got %h expected cafef00d", rd); end
    endtask

    task automatic test_input_change;
        rv32i_word rd; int lat;
        txn(2, 0, 1, 32'h54, 32'h3333_3333, 4'hF, rd, lat);
        drive(2, 0, 1, 32'h50, 32'h1111_1111, 4'hF);
        @(posedge clk); #1;
        checks++; if (bus2.mem_resp !== 1'b0) begin failures++; $display("FAIL chg_busy_resp: got %b expected 0", bus2.mem_resp); end
        drive(2, 1, 0, 32'h54, 32'h2222_2222, 4'h3);
        @(posedge clk); #1;
        checks++; if (bus2.mem_resp !== 1'b1) begin failures++; $display("FAIL chg_resp: got %b expected 1", bus2.mem_resp); end
        $display("txn dut=L2 write 0x50 with inputs changed in BUSY resp=%b", bus2.mem_resp);
        drive(2, 0, 0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        txn(2, 1, 0, 32'h50, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h1111_1111) begin failures++; $display("FAIL chg_captured_write: got %h expected 11111111", rd); end
        txn(2, 1, 0, 32'h54, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h3333_3333) begin failures++; $display("FAIL chg_other_word: got %h expected 33333333", rd); end
        checks++; if (bus2.proto_err !== EXP_PERR) begin failures++; $display("FAIL chg_perr: got %b expected %b", bus2.proto_err, EXP_PERR); end
    endtask

    task automatic test_reset_mid;
        rv32i_word rd; int lat; int seen;
        txn(2, 0, 1, 32'h40, 32'hA5A5_0001, 4'hF, rd, lat);
        drive(2, 0, 1, 32'h40, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (bus2.proto_err !== 1'b0) begin failures++; $display("FAIL midrst_perr: got %b expected 0", bus2.proto_err); end
        checks++; if (bus2.mem_rdata !== 32'h0) begin failures++; $display("FAIL midrst_rdata: got %h expected 00000000", bus2.mem_rdata); end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus2.mem_resp) seen++;
            if (i == 0) drive(2, 0, 0, 32'h0, 32'h0, 4'h0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus2.mem_resp) seen++;
        end
        $display("txn dut=L2 write 0x40 interrupted by reset resp_count=%0d", seen);
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_resp: got %0d pulses expected 0", seen); end
        txn(2, 1, 0, 32'h40, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'hA5A5_0001) begin failures++; $display("FAIL midrst_ram: got %h expected a5a50001", rd); end
    endtask

    task automatic test_lat1_back_to_back;
        drive(1, 0, 1, 32'h8, 32'h5A5A_5A5A, 4'hF);
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b1) begin failures++; $display("FAIL l1_first_resp: got %b expected 1", bus1.mem_resp); end
        $display("txn dut=L1 write 0x8 data=5a5a5a5a resp=%b", bus1.mem_resp);
        drive(1, 1, 0, 32'h8, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b0) begin failures++; $display("FAIL l1_gap: got %b expected 0", bus1.mem_resp); end
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b1) begin failures++; $display("FAIL l1_second_resp: got %b expected 1", bus1.mem_resp); end
        checks++; if (bus1.mem_rdata !== 32'h5A5A_5A5A) begin failures++; $display("FAIL l1_fetch_data: got %h expected 5a5a5a5a", bus1.mem_rdata); end
        $display("txn dut=L1 read 0x8 resp=%b rdata=%h", bus1.mem_resp, bus1.mem_rdata);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (bus1.mem_resp !== 1'b0) begin failures++; $display("FAIL l1_resp_end: got %b expected 0", bus1.mem_resp); end
    endtask

    task automatic test_abort;
        rv32i_word rd; int lat; int seen;
        txn(4, 0, 1, 32'h60, 32'h0F0F_0F0F, 4'hF, rd, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL l4_latency: got %0d expected 4", lat); end
        checks++; if (bus4.proto_err !== 1'b0) begin failures++; $display("FAIL l4_perr_clean: got %b expected 0", bus4.proto_err); end
        drive(4, 0, 1, 32'h60, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        drive(4, 0, 0, 32'h60, 32'hFFFF_FFFF, 4'hF);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus4.mem_resp) seen++;
        end
        $display("txn dut=L4 write 0x60 dropped after 1 cycle resp_count=%0d", seen);
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_resp: got %0d pulses expected 0", seen); end
        checks++; if (bus4.proto_err !== EXP_PERR) begin failures++; $display("FAIL abort_perr: got %b expected %b", bus4.proto_err, EXP_PERR); end
        txn(4, 1, 0, 32'h60, 32'h0, 4'h0, rd, lat);
        checks++; if (rd !== 32'h0F0F_0F0F) begin failures++; $display("FAIL abort_ram: got %h expected 0f0f0f0f", rd); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL abort_next_latency: got %0d expected 4", lat); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_byte_enable();
        test_wrap();
        test_back_to_back();
        test_rw_both();
        test_input_change();
        test_reset_mid();
        test_lat1_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
